// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Radix-2 shift-add multiply and restoring divide on operand magnitudes,
//   with a sign fix-up at the end. One accepted op runs DATA_WIDTH CALC cycles
//   plus one DONE cycle, so start in cycle 0 gives done in cycle 33.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request pulse, sampled only in IDLE
//   funct3             RV32M op select (MUL..REMU)
//   rs1_val, rs2_val   operands A and B
//   rd_in              destination register
//   flush              synchronous abort of the in-flight op
//   busy               high in CALC and DONE
//   done               one-cycle completion strobe
//   result             result, held until replaced by the next completion
//   rd_out             latched destination register
//   we                 register file write enable (suppressed for rd 0)
// Configuration:
//   MULDIV_DIV_EN      define to build the divider (DIV/DIVU/REM/REMU). When
//                      undefined, funct3[2]=1 ops complete with result 0, we 0.
module muldiv_unit #(
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [2:0]                     funct3,
  input  logic [DATA_WIDTH-1:0]          rs1_val,
  input  logic [DATA_WIDTH-1:0]          rs2_val,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_in,
  input  logic                           flush,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          result,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rd_out,
  output logic                           we
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op;
  logic [W-1:0]  hi;     // product high half / partial remainder
  logic [W-1:0]  lo;     // multiplier, becoming product low half / dividend becoming quotient
  logic [W-1:0]  opnd;   // multiplicand magnitude / divisor magnitude
  logic          neg_q;  // negate product or quotient at the end
  logic          wr_en;
`ifdef MULDIV_DIV_EN
  logic          neg_r;  // negate remainder at the end
  logic [W:0]    cand;
  logic [W:0]    diff;
`endif

  logic          a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    sum;
  logic [W-1:0]  hi_n, lo_n;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]  fin;

  // Operand signedness and magnitudes at accept time.
  always_comb begin
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_signed & rs1_val[W-1];
    b_neg    = b_signed & rs2_val[W-1];
    a_mag    = a_neg ? -rs1_val : rs1_val;
    b_mag    = b_neg ? -rs2_val : rs2_val;
  end

  // One iteration of the datapath plus the final sign fix-up.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    hi_n = sum[W:1];
    lo_n = {sum[0], lo[W-1:1]};
`ifdef MULDIV_DIV_EN
    cand = {hi, lo[W-1]};
    diff = cand - {1'b0, opnd};
    if (op[2]) begin
      if (cand >= {1'b0, opnd}) begin
        hi_n = diff[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = cand[W-1:0];
        lo_n = {lo[W-2:0], 1'b0};
      end
    end
`endif
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    fin    = (op[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
`ifdef MULDIV_DIV_EN
    if (op[2])
      fin = op[1] ? (neg_r ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n);
`else
    if (op[2])
      fin = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      wr_en  <= 1'b0;
      result <= '0;
      rd_out <= '0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state  <= CALC;
            cnt    <= '0;
            op     <= funct3;
            rd_out <= rd_in;
            hi     <= '0;
            opnd   <= a_mag;
            lo     <= b_mag;
            neg_q  <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            wr_en  <= (rd_in != '0);
            neg_r  <= a_neg;
            if (funct3[2]) begin
              opnd  <= b_mag;
              lo    <= a_mag;
              // Divide by zero keeps the all-ones quotient unsigned.
              neg_q <= (a_neg ^ b_neg) && (rs2_val != '0);
            end
`else
            wr_en  <= (rd_in != '0) && !funct3[2];
`endif
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= DONE;
              result <= fin;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // done/we are gated by flush so a flush during DONE still suppresses them.
  assign busy = (state != IDLE);
  assign done = (state == DONE) && !flush;
  assign we   = done && wr_en;

endmodule
